// File: rtl/alu_pkg.sv
// alu_pkg: shared width, opcode and FSM state definitions for the ALU command controller
package alu_pkg;
    localparam int W    = 8;
    localparam int NREG = 4;
    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_NOR  = 3'b101;
    localparam logic [2:0] OP_NAND = 3'b110;
    localparam logic [2:0] OP_PASS = 3'b111;
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: 4x8 register file, writeback beats host write on the same register
module alu_regfile
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en,
    input  logic [1:0]   wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic         wb_en,
    input  logic [1:0]   wb_addr,
    input  logic [W-1:0] wb_data,
    input  logic [1:0]   rd_addr,
    input  logic [1:0]   rs1,
    input  logic [1:0]   rs2,
    output logic [W-1:0] rd_data,
    output logic [W-1:0] rs1_data,
    output logic [W-1:0] rs2_data
);
    logic [W-1:0] regs_q [NREG];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) regs_q <= '{default: '0};
        else
            for (int i = 0; i < NREG; i++)
                regs_q[i] <= (wb_en && wb_addr == 2'(i)) ? wb_data :
                             (wr_en && wr_addr == 2'(i)) ? wr_data : regs_q[i];
    end

    assign rd_data  = regs_q[rd_addr];
    assign rs1_data = regs_q[rs1];
    assign rs2_data = regs_q[rs2];
endmodule

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: issues register-to-register commands to an external ALU and returns results
module alu_cmd_ctrl
    import alu_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [2:0]   cmd_op,
    input  logic [1:0]   cmd_rd,
    input  logic [1:0]   cmd_rs1,
    input  logic [1:0]   cmd_rs2,
    input  logic         wr_en,
    input  logic [1:0]   wr_addr,
    input  logic [W-1:0] wr_data,
    input  logic [1:0]   rd_addr,
    output logic [W-1:0] rd_data,
    output logic [W-1:0] alu_a,
    output logic [W-1:0] alu_b,
    output logic [2:0]   alu_op,
    input  logic [W-1:0] alu_out,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [W-1:0] rsp_data,
    output logic         rsp_zero,
    output logic         busy,
    output logic [7:0]   op_count
);
    state_t       state_q;
    logic [1:0]   rd_q;
    logic [W-1:0] alu_a_q, alu_b_q, rsp_data_q, rs1_data, rs2_data;
    logic [2:0]   alu_op_q;
    logic         rsp_valid_q, rsp_zero_q;
    logic [7:0]   op_count_q;

    alu_regfile u_regfile (
        .clk      (clk),
        .rst      (rst),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wb_en    (state_q == EXEC),
        .wb_addr  (rd_q),
        .wb_data  (alu_out),
        .rd_addr  (rd_addr),
        .rs1      (cmd_rs1),
        .rs2      (cmd_rs2),
        .rd_data  (rd_data),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            rd_q        <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_op_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_zero_q  <= 1'b0;
            op_count_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (cmd_valid) begin
                    alu_a_q  <= rs1_data;
                    alu_b_q  <= rs2_data;
                    alu_op_q <= cmd_op;
                    rd_q     <= cmd_rd;
                    state_q  <= EXEC;
                end
                EXEC: begin
                    rsp_data_q  <= alu_out;
                    rsp_zero_q  <= alu_out == '0;
                    rsp_valid_q <= 1'b1;
                    op_count_q  <= op_count_q + 8'd1;
                    state_q     <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign cmd_ready = state_q == IDLE;
    assign busy      = state_q != IDLE;
    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_op    = alu_op_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_zero  = rsp_zero_q;
    assign op_count  = op_count_q;
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb_alu_cmd_ctrl: transaction model plus response scoreboard for alu_cmd_ctrl
module tb_alu_cmd_ctrl;
    logic       clk = 0, rst = 1;
    logic       cmd_valid = 0, cmd_ready, wr_en = 0, rsp_valid, rsp_ready = 0, rsp_zero, busy;
    logic [2:0] cmd_op = 0, alu_op;
    logic [1:0] cmd_rd = 0, cmd_rs1 = 0, cmd_rs2 = 0, wr_addr = 0, rd_addr = 0;
    logic [7:0] wr_data = 0, rd_data, alu_a, alu_b, alu_out, rsp_data, op_count;

    typedef struct {logic [7:0] d; bit z; int c;} exp_t;
    exp_t q[$];
    logic [7:0] m [4];
    logic [7:0] cnt, wb_res, ex_a, ex_b;
    logic [2:0] ex_op;
    logic [1:0] wb_rd;
    bit wb_due, hold, seen;
    int acc_cnt, done_cnt, cyc, n_cmp, n_err;

    alu_cmd_ctrl dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data), .alu_a(alu_a), .alu_b(alu_b),
        .alu_op(alu_op), .alu_out(alu_out), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_zero(rsp_zero), .busy(busy), .op_count(op_count)
    );

    function automatic logic [7:0] alu_fn(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return ~(a | b);
            3'd6: return ~(a & b);
            default: return a;
        endcase
    endfunction

    assign alu_out = alu_fn(alu_a, alu_b, alu_op);

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // One clock of stimulus: check the settled state, drive inputs, predict the next edge.
    task automatic step(input bit v, input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs1,
                        input logic [1:0] rs2, input bit we, input logic [1:0] wa, input logic [7:0] wd,
                        input logic [1:0] ra);
        logic [7:0] nm [4];
        logic [7:0] ncnt, r;
        bit rdy, acc;
        @(negedge clk);
        rdy = acc_cnt == done_cnt;
        chk("cmd_ready", cmd_ready, rdy);
        chk("busy", busy, !rdy);
        chk("rd_data", rd_data, m[rd_addr]);
        chk("op_count", op_count, cnt);
        if (wb_due) begin
            chk("alu_a", alu_a, ex_a);
            chk("alu_b", alu_b, ex_b);
            chk("alu_op", alu_op, ex_op);
        end
        cmd_valid = v; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2;
        wr_en = we; wr_addr = wa; wr_data = wd; rd_addr = ra;
        nm = m;
        ncnt = cnt;
        if (we) nm[wa] = wd;
        if (wb_due) begin
            nm[wb_rd] = wb_res;
            ncnt = cnt + 8'd1;
        end
        acc = v && rdy;
        if (acc) begin
            r = alu_fn(m[rs1], m[rs2], op);
            q.push_back('{r, r == 0, cyc});
            acc_cnt++;
            ex_a = m[rs1]; ex_b = m[rs2]; ex_op = op; wb_rd = rd; wb_res = r;
        end
        @(posedge clk);
        m = nm;
        cnt = ncnt;
        wb_due = acc;
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && acc_cnt != done_cnt; i++) step(0, 0, 0, 0, 0, 0, 0, 0, rd_addr);
        if (acc_cnt != done_cnt) chk("drain_timeout", done_cnt, acc_cnt);
        step(0, 0, 0, 0, 0, 0, 0, 0, rd_addr);
    endtask

    task automatic peek(input logic [1:0] a, input logic [7:0] exp, input string name);
        rd_addr = a;
        #1 chk(name, rd_data, exp);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                rsp_ready = 0;
                seen = 0;
            end else if (rsp_valid) begin
                if (q.size() == 0) chk("rsp_valid_unexpected", rsp_valid, 0);
                else begin
                    chk("rsp_data", rsp_data, q[0].d);
                    chk("rsp_zero", rsp_zero, q[0].z);
                    if (!seen) chk("rsp_latency", cyc - q[0].c, 2);
                    seen = 1;
                    rsp_ready = !hold && ($urandom % 3 != 0);
                    if (rsp_ready) begin
                        void'(q.pop_front());
                        done_cnt++;
                        seen = 0;
                    end
                end
            end else rsp_ready = !hold && ($urandom % 2 == 0);
        end
    end

    initial begin
        for (int i = 0; i < 4; i++) m[i] = 0;
        cnt = 0;
        @(negedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_op_count", op_count, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_zero", rsp_zero, 0);
        chk("rst_rd_data", rd_data, 0);
        @(negedge clk) rst = 0;
        step(0, 0, 0, 0, 0, 1, 0, 8'h3C, 0);
        step(0, 0, 0, 0, 0, 1, 1, 8'h0F, 0);
        step(1, 3'd0, 2, 0, 1, 0, 0, 0, 2);
        drain();
        peek(2, 8'h4B, "add_R2");
        chk("add_op_count", op_count, 1);
        step(1, 3'd1, 3, 1, 0, 0, 0, 0, 3);
        drain();
        peek(3, 8'hD3, "sub_wrap_R3");
        step(1, 3'd4, 0, 0, 0, 0, 0, 0, 0);
        drain();
        peek(0, 8'h00, "xor_zero_R0");
        hold = 1;
        for (int i = 0; i < 8; i++) step(1, 3'd3, 1, 2, 3, 0, 0, 0, 1);
        hold = 0;
        for (int i = 0; i < 4; i++) step(1, 3'd3, 1, 2, 3, 0, 0, 0, 1);
        drain();
        peek(1, 8'hDB, "or_R1");
        step(0, 0, 0, 0, 0, 1, 0, 8'h3C, 0);
        step(0, 0, 0, 0, 0, 1, 1, 8'h0F, 0);
        step(1, 3'd0, 2, 0, 1, 0, 0, 0, 2);
        step(0, 0, 0, 0, 0, 1, 2, 8'h55, 2);
        drain();
        peek(2, 8'h4B, "collide_same_R2");
        step(1, 3'd0, 3, 0, 1, 0, 0, 0, 3);
        step(0, 0, 0, 0, 0, 1, 1, 8'h77, 3);
        drain();
        peek(3, 8'h4B, "collide_diff_R3");
        peek(1, 8'h77, "collide_diff_R1");
        // Reset lands while the command is in its execute cycle.
        step(1, 3'd0, 0, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        cmd_valid = 0; wr_en = 0; rst = 1;
        q.delete();
        acc_cnt = 0; done_cnt = 0; wb_due = 0; cnt = 0;
        for (int i = 0; i < 4; i++) m[i] = 0;
        #1;
        chk("mid_rst_rsp_valid", rsp_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_op_count", op_count, 0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) peek(2'(i), 8'h00, "mid_rst_reg");
        @(negedge clk) rst = 0;
        for (int i = 0; i < 1500; i++)
            step($urandom % 10 < 7, 3'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                 $urandom % 4 == 0, 2'($urandom), 8'($urandom), 2'($urandom));
        drain();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
